// File: rtl/axis_32to64.sv
// axis_32to64: packs 32-bit AXI-Stream words into 64-bit big-endian beats
// for the SRIO Tx user interface, realigning the partial last word to the
// MSB lanes and flagging illegal keep patterns and over-length packets.
// Optional feature macro: AXIS_32TO64_PKT_LEN_EN adds the pkt_len output.
module axis_32to64 #(
    parameter int         MAX_PKT_BYTES = 256,
    parameter logic [7:0] PAD_BYTE      = 8'h00
) (
    input  logic        clk_32,
    input  logic        reset_32_n,
    input  logic [31:0] axis_tdata_in,
    input  logic [3:0]  axis_tkeep_in,
    input  logic        axis_tvalid_in,
    input  logic        axis_tlast_in,
    output logic        axis_tready_out,
    output logic [63:0] axis_tdata_out,
    output logic [7:0]  axis_tkeep_out,
    output logic        axis_tvalid_out,
    output logic        axis_tlast_out,
    input  logic        axis_tready_in,
    output logic        keep_err,
    output logic        len_err
`ifdef AXIS_32TO64_PKT_LEN_EN
    ,
    output logic [8:0]  pkt_len
`endif
);

    typedef enum logic {
        S_LOW  = 1'b0,
        S_HIGH = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] hold_word;
    logic [8:0]  byte_cnt;

    logic        accept;
    logic        out_xfer;
    logic [2:0]  word_bytes;
    logic        keep_bad;
    logic [31:0] word_aligned;
    logic [3:0]  keep_aligned;
    logic [9:0]  cnt_sum;
    logic [8:0]  cnt_sat;

    logic        load_beat;
    logic        store_hold;
    logic [63:0] beat_data;
    logic [7:0]  beat_keep;
    logic        beat_last;

    // The output register can take a new beat whenever it is empty or is
    // being drained in this very cycle, so back-to-back beats need no bubble.
    assign out_xfer        = axis_tvalid_out & axis_tready_in;
    assign axis_tready_out = ~axis_tvalid_out | axis_tready_in;
    assign accept          = axis_tvalid_in & axis_tready_out;

    // Decode how many bytes the current word carries; illegal patterns are
    // flagged and the word is then treated as a full four bytes.
    always_comb begin
        word_bytes = 3'd4;
        keep_bad   = 1'b0;
        if (!axis_tlast_in) begin
            keep_bad = (axis_tkeep_in != 4'b1111);
        end else begin
            case (axis_tkeep_in)
                4'b0001: word_bytes = 3'd1;
                4'b0011: word_bytes = 3'd2;
                4'b0111: word_bytes = 3'd3;
                4'b1111: word_bytes = 3'd4;
                default: keep_bad   = 1'b1;
            endcase
        end
    end

    // Move the LSB-aligned valid bytes up to the MSB lanes and pad the rest.
    always_comb begin
        word_aligned = axis_tdata_in;
        keep_aligned = 4'b1111;
        case (word_bytes)
            3'd1: begin
                word_aligned = {axis_tdata_in[7:0], {3{PAD_BYTE}}};
                keep_aligned = 4'b1000;
            end
            3'd2: begin
                word_aligned = {axis_tdata_in[15:0], {2{PAD_BYTE}}};
                keep_aligned = 4'b1100;
            end
            3'd3: begin
                word_aligned = {axis_tdata_in[23:0], PAD_BYTE};
                keep_aligned = 4'b1110;
            end
            default: begin
                word_aligned = axis_tdata_in;
                keep_aligned = 4'b1111;
            end
        endcase
    end

    // Running packet length, saturating at the 9-bit ceiling.
    always_comb begin
        cnt_sum = {1'b0, byte_cnt} + {7'd0, word_bytes};
        cnt_sat = cnt_sum[9] ? 9'h1FF : cnt_sum[8:0];
    end

    // Next-state and beat assembly: a beat completes on any word taken in
    // S_HIGH, or on a last word taken in S_LOW (lower half left empty).
    always_comb begin
        state_next = state;
        load_beat  = 1'b0;
        store_hold = 1'b0;
        beat_data  = {word_aligned, {4{PAD_BYTE}}};
        beat_keep  = {keep_aligned, 4'b0000};
        beat_last  = 1'b1;
        case (state)
            S_LOW: begin
                if (accept) begin
                    if (axis_tlast_in) begin
                        load_beat = 1'b1;
                    end else begin
                        store_hold = 1'b1;
                        state_next = S_HIGH;
                    end
                end
            end
            S_HIGH: begin
                beat_data = {hold_word, word_aligned};
                beat_keep = {4'b1111, keep_aligned};
                beat_last = axis_tlast_in;
                if (accept) begin
                    load_beat  = 1'b1;
                    state_next = S_LOW;
                end
            end
            default: state_next = S_LOW;
        endcase
    end

    // State register.
    always_ff @(posedge clk_32) begin
        if (!reset_32_n) begin
            state <= S_LOW;
        end else begin
            state <= state_next;
        end
    end

    // Upper-half hold register for the first word of each beat.
    always_ff @(posedge clk_32) begin
        if (!reset_32_n) begin
            hold_word <= 32'd0;
        end else if (store_hold) begin
            hold_word <= axis_tdata_in;
        end
    end

    // Per-packet byte counter, restarted after each last word.
    always_ff @(posedge clk_32) begin
        if (!reset_32_n) begin
            byte_cnt <= 9'd0;
        end else if (accept) begin
            byte_cnt <= axis_tlast_in ? 9'd0 : cnt_sat;
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk_32) begin
        if (!reset_32_n) begin
            keep_err <= 1'b0;
            len_err  <= 1'b0;
        end else if (accept) begin
            if (keep_bad) begin
                keep_err <= 1'b1;
            end
            if (cnt_sum > 10'(MAX_PKT_BYTES)) begin
                len_err <= 1'b1;
            end
        end
    end

    // Output register: loads a completed beat, otherwise empties on transfer
    // and holds everything stable while the downstream stalls.
    always_ff @(posedge clk_32) begin
        if (!reset_32_n) begin
            axis_tdata_out  <= 64'd0;
            axis_tkeep_out  <= 8'd0;
            axis_tlast_out  <= 1'b0;
            axis_tvalid_out <= 1'b0;
        end else if (load_beat) begin
            axis_tdata_out  <= beat_data;
            axis_tkeep_out  <= beat_keep;
            axis_tlast_out  <= beat_last;
            axis_tvalid_out <= 1'b1;
        end else if (out_xfer) begin
            axis_tvalid_out <= 1'b0;
        end
    end

`ifdef AXIS_32TO64_PKT_LEN_EN
    // Packet length travels with the last beat and reads 0 at all other times.
    always_ff @(posedge clk_32) begin
        if (!reset_32_n) begin
            pkt_len <= 9'd0;
        end else if (load_beat) begin
            pkt_len <= beat_last ? cnt_sat : 9'd0;
        end else if (out_xfer) begin
            pkt_len <= 9'd0;
        end
    end
`else
    // Without pkt_len the byte counter only feeds the len_err check.
`endif

endmodule

// File: tb/tb_axis_32to64.sv
// Testbench for axis_32to64: byte-stream reference model compared every
// cycle, directed packets pinned to literal beats, plus random packets.
// Honours AXIS_32TO64_PKT_LEN_EN when the design is built with it.
module tb_axis_32to64;

    localparam logic [7:0] PAD = 8'h00;
    localparam int MAX_BYTES = 256;

    logic        clk_32 = 1'b0;
    logic        reset_32_n;
    logic [31:0] axis_tdata_in;
    logic [3:0]  axis_tkeep_in;
    logic        axis_tvalid_in;
    logic        axis_tlast_in;
    logic        axis_tready_out;
    logic [63:0] axis_tdata_out;
    logic [7:0]  axis_tkeep_out;
    logic        axis_tvalid_out;
    logic        axis_tlast_out;
    logic        axis_tready_in;
    logic        keep_err;
    logic        len_err;
`ifdef AXIS_32TO64_PKT_LEN_EN
    logic [8:0]  pkt_len;
`endif

    axis_32to64 #(.MAX_PKT_BYTES(MAX_BYTES), .PAD_BYTE(PAD)) dut (
        .clk_32         (clk_32),
        .reset_32_n     (reset_32_n),
        .axis_tdata_in  (axis_tdata_in),
        .axis_tkeep_in  (axis_tkeep_in),
        .axis_tvalid_in (axis_tvalid_in),
        .axis_tlast_in  (axis_tlast_in),
        .axis_tready_out(axis_tready_out),
        .axis_tdata_out (axis_tdata_out),
        .axis_tkeep_out (axis_tkeep_out),
        .axis_tvalid_out(axis_tvalid_out),
        .axis_tlast_out (axis_tlast_out),
        .axis_tready_in (axis_tready_in),
        .keep_err       (keep_err),
        .len_err        (len_err)
`ifdef AXIS_32TO64_PKT_LEN_EN
        ,
        .pkt_len        (pkt_len)
`endif
    );

    always #5 clk_32 = ~clk_32;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [8:0]  plen;
    } beat_t;

    int pass_count  = 0;
    int total_count = 0;

    // Reference model state
    beat_t      exp_q[$];
    logic [7:0] pend[$];
    int         pkt_total = 0;
    bit         exp_keep_err = 1'b0;
    bit         exp_len_err  = 1'b0;
    bit         armed = 1'b0;

    // Log of beats the DUT actually handed downstream
    beat_t      dut_log[$];

    int ready_mode = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_count++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            pass_count++;
        end
    endtask

    function automatic int legalBytes(input logic [3:0] k, input logic l);
        if (!l) return 4;
        case (k)
            4'b0001: return 1;
            4'b0011: return 2;
            4'b0111: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic bit keepIllegal(input logic [3:0] k, input logic l);
        if (!l) return (k != 4'b1111);
        return !(k == 4'b0001 || k == 4'b0011 || k == 4'b0111 || k == 4'b1111);
    endfunction

    // Take up to eight pending bytes, MSB lane first, as one expected beat.
    task automatic emitBeat(input bit l);
        beat_t b;
        b.data = {8{PAD}};
        b.keep = 8'h00;
        b.last = l;
        for (int j = 0; j < 8; j++) begin
            if (pend.size() > 0) begin
                b.data[63-8*j -: 8] = pend.pop_front();
                b.keep[7-j] = 1'b1;
            end
        end
        b.plen = l ? 9'((pkt_total > 511) ? 511 : pkt_total) : 9'd0;
        exp_q.push_back(b);
    endtask

    task automatic modelAccept(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        n = legalBytes(k, l);
        if (keepIllegal(k, l)) exp_keep_err = 1'b1;
        for (int i = 0; i < n; i++) pend.push_back(d[8*(n-1-i) +: 8]);
        pkt_total += n;
        if (pkt_total > MAX_BYTES) exp_len_err = 1'b1;
        if (pend.size() >= 8 || l) emitBeat(l);
        if (l) pkt_total = 0;
    endtask

    // Compare every output against the model on the falling edge, then
    // advance the model by whatever handshakes the next rising edge commits.
    initial begin
        forever begin
            @(negedge clk_32);
            if (armed) begin
                bit ev;
                bit xfer;
                ev   = (exp_q.size() > 0);
                xfer = ev && axis_tready_in;
                checkOutput("tvalid_out", 64'(axis_tvalid_out), 64'(ev));
                checkOutput("tready_out", 64'(axis_tready_out), 64'(!ev || axis_tready_in));
                checkOutput("keep_err", 64'(keep_err), 64'(exp_keep_err));
                checkOutput("len_err", 64'(len_err), 64'(exp_len_err));
                if (ev && axis_tvalid_out) begin
                    checkOutput("tdata_out", axis_tdata_out, exp_q[0].data);
                    checkOutput("tkeep_out", 64'(axis_tkeep_out), 64'(exp_q[0].keep));
                    checkOutput("tlast_out", 64'(axis_tlast_out), 64'(exp_q[0].last));
`ifdef AXIS_32TO64_PKT_LEN_EN
                    checkOutput("pkt_len", 64'(pkt_len), 64'(exp_q[0].plen));
`endif
                end
`ifdef AXIS_32TO64_PKT_LEN_EN
                else begin
                    checkOutput("pkt_len idle", 64'(pkt_len), 64'd0);
                end
`endif
                if (axis_tvalid_out && axis_tready_in) begin
                    beat_t o;
                    o.data = axis_tdata_out;
                    o.keep = axis_tkeep_out;
                    o.last = axis_tlast_out;
`ifdef AXIS_32TO64_PKT_LEN_EN
                    o.plen = pkt_len;
`else
                    o.plen = 9'd0;
`endif
                    dut_log.push_back(o);
                end
                if (xfer) void'(exp_q.pop_front());
                if (reset_32_n && axis_tvalid_in && (!ev || axis_tready_in)) begin
                    modelAccept(axis_tdata_in, axis_tkeep_in, axis_tlast_in);
                end
            end
            if (!reset_32_n) begin
                exp_q.delete();
                pend.delete();
                pkt_total    = 0;
                exp_keep_err = 1'b0;
                exp_len_err  = 1'b0;
                armed        = 1'b1;
            end
        end
    end

    // Downstream ready pattern: 0 always, 1 toggle, 2 random, 3 test-driven.
    initial begin
        axis_tready_in = 1'b1;
        forever begin
            @(posedge clk_32);
            #1;
            case (ready_mode)
                0: axis_tready_in = 1'b1;
                1: axis_tready_in = ~axis_tready_in;
                2: axis_tready_in = ($urandom_range(0, 3) != 0);
                default: ;
            endcase
        end
    end

    // Present one word and hold it until the DUT takes it.
    task automatic applyStimulus(input logic [31:0] d, input logic [3:0] k, input logic l);
        int waited;
        waited = 0;
        axis_tdata_in  = d;
        axis_tkeep_in  = k;
        axis_tlast_in  = l;
        axis_tvalid_in = 1'b1;
        @(negedge clk_32);
        while (!axis_tready_out && waited < 200) begin
            @(negedge clk_32);
            waited++;
        end
        if (waited >= 200) checkOutput("accept timeout", 64'd1, 64'd0);
        @(posedge clk_32);
        #1;
        axis_tvalid_in = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk_32);
        #1;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || axis_tvalid_out) && n < 1000) begin
            @(negedge clk_32);
            n++;
        end
        if (n >= 1000) checkOutput("drain timeout", 64'd1, 64'd0);
        @(posedge clk_32);
        #1;
    endtask

    task automatic pulseReset();
        @(posedge clk_32);
        #1;
        reset_32_n = 1'b0;
        @(posedge clk_32);
        #1;
        reset_32_n = 1'b1;
    endtask

    task automatic checkLog(input int idx, input logic [63:0] d, input logic [7:0] k,
                            input logic l, input string tag);
        if (idx >= dut_log.size()) begin
            checkOutput({tag, " beat missing"}, 64'(dut_log.size()), 64'(idx + 1));
        end else begin
            checkOutput({tag, " data"}, dut_log[idx].data, d);
            checkOutput({tag, " keep"}, 64'(dut_log[idx].keep), 64'(k));
            checkOutput({tag, " last"}, 64'(dut_log[idx].last), 64'(l));
        end
    endtask

    // Random packet: full words, last word of 1..4 bytes, rare illegal keep.
    task automatic randomPacket();
        int nw;
        logic [3:0] k;
        logic [3:0] lastk [4];
        lastk[0] = 4'b0001; lastk[1] = 4'b0011; lastk[2] = 4'b0111; lastk[3] = 4'b1111;
        nw = $urandom_range(1, 12);
        for (int i = 0; i < nw; i++) begin
            k = (i == nw - 1) ? lastk[$urandom_range(0, 3)] : 4'b1111;
            if ($urandom_range(0, 15) == 0) k = 4'($urandom_range(0, 15));
            applyStimulus($urandom, k, (i == nw - 1));
            if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 2));
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        reset_32_n     = 1'b0;
        axis_tdata_in  = 32'd0;
        axis_tkeep_in  = 4'd0;
        axis_tvalid_in = 1'b0;
        axis_tlast_in  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk_32);
        @(negedge clk_32);
        checkOutput("reset tvalid_out", 64'(axis_tvalid_out), 64'd0);
        checkOutput("reset tlast_out", 64'(axis_tlast_out), 64'd0);
        checkOutput("reset tkeep_out", 64'(axis_tkeep_out), 64'd0);
        checkOutput("reset tdata_out", axis_tdata_out, 64'd0);
        checkOutput("reset keep_err", 64'(keep_err), 64'd0);
        checkOutput("reset len_err", 64'(len_err), 64'd0);
        @(posedge clk_32);
        #1;
        reset_32_n = 1'b1;
        idleCycles(2);

        // 8-byte packet, output one cycle after the second accept
        ready_mode = 0;
        dut_log.delete();
        applyStimulus(32'h01020304, 4'hF, 1'b0);
        applyStimulus(32'h05060708, 4'hF, 1'b1);
        checkOutput("t1 latency valid", 64'(axis_tvalid_out), 64'd1);
        waitDrain();
        checkOutput("t1 beat count", 64'(dut_log.size()), 64'd1);
        checkLog(0, 64'h0102030405060708, 8'hFF, 1'b1, "t1");

        // 7-byte and 5-byte packets, then a 1-byte packet
        dut_log.delete();
        applyStimulus(32'h11223344, 4'hF, 1'b0);
        applyStimulus(32'h00556677, 4'b0111, 1'b1);
        applyStimulus(32'hAABBCCDD, 4'hF, 1'b0);
        applyStimulus(32'h000000EE, 4'b0001, 1'b1);
        applyStimulus(32'h00000099, 4'b0001, 1'b1);
        waitDrain();
        checkLog(0, 64'h1122334455667700, 8'hFE, 1'b1, "t2");
        checkLog(1, 64'hAABBCCDDEE000000, 8'hF8, 1'b1, "t3a");
        checkLog(2, 64'h9900000000000000, 8'h80, 1'b1, "t3b");

        // 16 back-to-back words with a toggling downstream ready
        ready_mode = 1;
        dut_log.delete();
        for (int i = 0; i < 16; i++) applyStimulus(32'hC0DE0000 + 32'(i), 4'hF, (i == 15));
        waitDrain();
        checkOutput("t4 beat count", 64'(dut_log.size()), 64'd8);
        for (int b = 0; b < 8; b++) begin
            checkLog(b, {32'hC0DE0000 + 32'(2*b), 32'hC0DE0000 + 32'(2*b+1)},
                     8'hFF, (b == 7), "t4");
        end

        // Random packets against the model
        ready_mode = 2;
        for (int p = 0; p < 30; p++) randomPacket();
        waitDrain();

        // Illegal keep on a non-last word, then an over-length packet
        ready_mode = 0;
        pulseReset();
        dut_log.delete();
        applyStimulus(32'h12345678, 4'b0011, 1'b0);
        applyStimulus(32'h9ABCDEF0, 4'hF, 1'b1);
        waitDrain();
        checkOutput("t5 keep_err", 64'(keep_err), 64'd1);
        checkOutput("t5 len_err before", 64'(len_err), 64'd0);
        checkLog(0, 64'h123456789ABCDEF0, 8'hFF, 1'b1, "t5a");
        dut_log.delete();
        ready_mode = 2;
        for (int i = 0; i < 65; i++) applyStimulus(32'h50000000 + 32'(i), 4'hF, (i == 64));
        waitDrain();
        checkOutput("t5 len_err", 64'(len_err), 64'd1);
        checkOutput("t5 keep_err sticky", 64'(keep_err), 64'd1);
        checkOutput("t5 beat count", 64'(dut_log.size()), 64'd33);
        checkLog(32, 64'h5000004000000000, 8'hF0, 1'b1, "t5b");

        // Reset with a stalled output beat pending
        ready_mode = 3;
        axis_tready_in = 1'b0;
        applyStimulus(32'hA0A0A0A0, 4'hF, 1'b0);
        applyStimulus(32'hB0B0B0B0, 4'hF, 1'b0);
        idleCycles(2);
        checkOutput("t6 stalled valid", 64'(axis_tvalid_out), 64'd1);
        checkOutput("t6 stalled ready", 64'(axis_tready_out), 64'd0);
        pulseReset();
        checkOutput("t6 valid after reset", 64'(axis_tvalid_out), 64'd0);

        // Reset while the upper half is held, then a 4-byte packet
        ready_mode = 0;
        idleCycles(1);
        dut_log.delete();
        applyStimulus(32'h55555555, 4'hF, 1'b0);
        pulseReset();
        applyStimulus(32'hDEADBEEF, 4'hF, 1'b1);
        waitDrain();
        checkOutput("t6 beat count", 64'(dut_log.size()), 64'd1);
        checkLog(0, 64'hDEADBEEF00000000, 8'hF0, 1'b1, "t6");
`ifdef AXIS_32TO64_PKT_LEN_EN
        if (dut_log.size() > 0) checkOutput("t6 pkt_len", 64'(dut_log[0].plen), 64'd4);
`endif

        // A few more random packets after the mid-packet reset
        ready_mode = 2;
        for (int p = 0; p < 10; p++) randomPacket();
        waitDrain();

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule

// File: doc/axis_32to64.md
Name: axis_32to64

Overview:
- Downstream neighbour of the 8-to-32 byte packer. It runs in the 32-bit read-clock domain after the async FIFO and packs 32-bit AXI-Stream words into 64-bit beats for the SRIO user (Tx) interface.
- It realigns the LSB-aligned partial last word into big-endian, MSB-first lane order.
- It checks keep legality and packet length against the SRIO maximum payload.

Parameters:
- MAX_PKT_BYTES, 256: largest legal packet in bytes. A packet longer than this sets len_err.
- PAD_BYTE, 8'h00: value driven on every output byte lane whose keep bit is 0.

Ports:
- clk_32  in  1  block clock; all logic on its rising edge
- reset_32_n  in  1  synchronous reset, active-low
- axis_tdata_in  in  32  input word; first byte of the word in [31:24]
- axis_tkeep_in  in  4  input keep; legal values are 4'b1111 on any beat, and 4'b0001/0011/0111 on the last beat only
- axis_tvalid_in  in  1  input valid
- axis_tlast_in  in  1  input last
- axis_tready_out  out  1  input ready
- axis_tdata_out  out  64  output beat; first byte in [63:56]
- axis_tkeep_out  out  8  output keep, MSB-contiguous (e.g. 8'hFF, 8'hF0, 8'hE0)
- axis_tvalid_out  out  1  output valid
- axis_tlast_out  out  1  output last
- axis_tready_in  in  1  downstream ready
- keep_err  out  1  sticky: illegal keep seen
- len_err  out  1  sticky: packet exceeded MAX_PKT_BYTES

Behaviour:
- Clock and reset:
  - Single clock clk_32. Reset is synchronous, active-low (reset_32_n).
  - Reset values: axis_tvalid_out=0, axis_tlast_out=0, axis_tkeep_out=0, axis_tdata_out=0, keep_err=0, len_err=0, state=S_LOW, byte counter=0.
- Handshakes:
  - Input accept = axis_tvalid_in & axis_tready_out.
  - Output transfer = axis_tvalid_out & axis_tready_in.
  - axis_tready_out = ~axis_tvalid_out | axis_tready_in. It does not depend on tvalid or tlast.
  - The output register holds data, keep and last stable while axis_tvalid_out=1 and axis_tready_in=0.
- Realignment: a last word with keep 0001/0011/0111 carries n valid bytes in data[8n-1:0]. It is shifted left by 8*(4-n) and its keep becomes 1000/1100/1110. Vacated lanes are driven with PAD_BYTE.
- State machine (two states):
  - S_LOW: upper half empty.
    - Accepted word, not last: store the word in the upper hold register, go to S_HIGH; nothing is emitted.
    - Accepted word, last: emit data {word_aligned, 4×PAD_BYTE}, keep {keep_aligned, 4'b0000}, last=1 on the next cycle; stay in S_LOW.
  - S_HIGH: upper half held.
    - Accepted word: emit data {hold, word_aligned}, keep {4'b1111, keep_aligned}, last=tlast_in on the next cycle; go to S_LOW.
- Latency and throughput:
  - Output appears one cycle after the accept that completes a beat.
  - Sustained rate: one 32-bit word per cycle in, one 64-bit beat every two cycles out, when the downstream ready stays high.
- Keep checks:
  - A non-last beat with keep≠1111 sets keep_err; the word is treated as 4 bytes.
  - A last beat with keep 0000 or a non-contiguous keep sets keep_err; the word is treated as 1111.
  - keep_err clears only on reset.
- Length check:
  - A 9-bit byte counter adds the legal byte count of each accepted word and clears after the last word.
  - If the running count exceeds MAX_PKT_BYTES, len_err is set (sticky). Data still passes unchanged and the counter saturates.
- Simultaneous events: an output transfer and a new-beat load in the same cycle is legal. The output register reloads with no bubble.
- Reset mid-packet: the held upper word and the pending output are discarded. The next accepted word starts a new packet in S_LOW.
- tlast without a preceding first word is a normal single-word packet.

Optional Feature:
- Macro: AXIS_32TO64_PKT_LEN_EN.
- When defined:
  - Adds output pkt_len [8:0], the total valid bytes of the packet, including the bytes of the last beat.
  - It is valid in the same cycle as axis_tvalid_out & axis_tlast_out and held stable with the beat. It is 0 otherwise and after reset.
- When undefined: the port is absent. The byte counter remains for the len_err check only.

Test Plan:
1. 8-byte packet, words 0x01020304, 0x05060708 (keep F, last on 2nd), tready_in=1 -> one beat 0x0102030405060708, keep FF, last=1, one cycle after the 2nd accept.
2. 7-byte packet, words 0x11223344 then 0x00556677 with keep 0111, last -> beat 0x1122334455667700, keep FE, last=1.
3. 5-byte packet, words 0xAABBCCDD then 0x000000EE with keep 0001, last -> beat 0xAABBCCDDEE000000, keep F8. A single 0x00000099 keep 0001 last -> 0x9900000000000000, keep 80.
4. 16 back-to-back words with tready_in toggled 1,0,1,0 -> no data loss, no duplication, tready_out low while the output is stalled, 8 beats in order, last only on beat 8.
5. Non-last word with keep 0011 -> keep_err=1 and it stays 1. A 260-byte packet (65 words) -> len_err=1, all data still delivered.
6. reset_32_n low for 1 cycle while in S_HIGH with a stalled output -> axis_tvalid_out=0 next cycle. A following 4-byte last packet yields keep F0. With the macro defined, pkt_len=4.
